gpu_pixel_writer: RTL and testbench
===================================

# gpu_pixel_writer

Downstream consumer of the fill-circle rasterizer's per-cycle pixel coordinate stream. Qualifies each coordinate, rejecting the off-screen sentinel and consecutive duplicates. Converts accepted pixels into linear framebuffer addresses with the current colour and buffers them in a small FIFO. Drains the FIFO to the framebuffer memory over a request/acknowledge write port, and signals when a primitive's pixels have all been committed.

## Interface
- WIDTH, 640: screen width in pixels; X value WIDTH is the off-screen sentinel.
- HEIGHT, 480: screen height in pixels; Y value HEIGHT is the sentinel.
- WIDTH_BITS, 10: X coordinate width.
- HEIGHT_BITS, 9: Y coordinate width.
- CHANNEL_BITS, 8: bits per colour channel.
- ADDR_BITS, 19: framebuffer address width; must satisfy 2^ADDR_BITS >= WIDTH*HEIGHT.
- FIFO_DEPTH, 8: write-buffer entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  synchronous, active-high reset.
- X_i  in  WIDTH_BITS  pixel X from the rasterizer.
- Y_i  in  HEIGHT_BITS  pixel Y from the rasterizer.
- r_i, g_i, b_i  in  CHANNEL_BITS each  current primitive colour.
- done_i  in  1  rasterizer done pulse, one cycle wide.
- mem_wr_o  out  1  write request.
- mem_addr_o  out  ADDR_BITS  write address, Y*WIDTH + X.
- mem_data_o  out  3*CHANNEL_BITS  write data, {r,g,b}.
- mem_ack_i  in  1  memory accepted the current write.
- fifo_full_o  out  1  FIFO holds FIFO_DEPTH entries.
- overflow_o  out  1  sticky flag; a valid pixel was dropped.
- done_o  out  1  one-cycle pulse; all pixels of the primitive have been written.

## Operation
- **Qualify (stage S1, registered):**
  - A coordinate is valid when X_i < WIDTH and Y_i < HEIGHT.
  - A valid coordinate is accepted unless it equals the last accepted coordinate and last_valid=1.
  - On acceptance, S1 latches X, Y and {r_i,g_i,b_i}, sets s1_valid, updates the last-accepted coordinate and sets last_valid.
  - Invalid or duplicate inputs clear s1_valid and leave last-accepted unchanged.
  - done_i clears last_valid, so a new primitive may repeat the final pixel of the previous one.
- **Address:** computed from the S1 register as Y*WIDTH + X. The product is formed at ADDR_BITS width and never truncated, since the maximum value is WIDTH*HEIGHT-1.
- **FIFO push:** when s1_valid=1, the {addr,data} entry is pushed.
  - A push while full and not popping in the same cycle drops the entry and sets overflow_o.
  - A push and pop in the same cycle while full succeeds; the count is unchanged.
- **Writer FSM:**
  - IDLE: mem_wr_o=0. Go to REQ when the FIFO is non-empty.
  - REQ: mem_wr_o=1, with mem_addr_o and mem_data_o driven from the FIFO head and held stable until ack.
    - On mem_ack_i, pop the entry.
    - Stay in REQ if the FIFO still holds entries after the pop (back-to-back writes, one per cycle with ack tied high); otherwise go to IDLE.
  - mem_ack_i while in IDLE is ignored.
- **Done tracking:**
  - done_i sets done_pending.
  - done_o pulses for one cycle when done_pending=1, s1_valid=0, the FIFO is empty and the FSM is in IDLE; done_pending clears in that same cycle.
  - If done_i arrives while done_pending is already set, only one pulse is produced.
- **Reset (synchronous, may occur mid-operation):**
  - FIFO, S1, last_valid, done_pending and overflow all clear; FSM goes to IDLE.
  - Outputs are mem_wr_o=0, mem_addr_o=0, mem_data_o=0, fifo_full_o=0, overflow_o=0, done_o=0.
  - An in-flight write is abandoned and a later mem_ack_i is ignored.

## Timing
- Input sampled at edge N is in S1 after N; it is pushed at edge N+1.
- With the FIFO previously empty and the FSM in IDLE, mem_wr_o rises after edge N+2. Input-to-request latency is 2 cycles.
- mem_addr_o and mem_data_o change only after an ack edge or when leaving IDLE.
- fifo_full_o is registered and reflects the count after the current edge.
- Sustained throughput is 1 pixel/cycle when mem_ack_i is tied high.
- done_o asserts no earlier than the cycle after the final ack.

## Test plan
- **Single pixel:** X=3, Y=2 for one cycle, then sentinel (640,480), ack tied 1 -> exactly one write with addr=1283 and data={r,g,b}; mem_wr_o high for 1 cycle, starting 2 cycles after input.
- **Duplicate filter:** inputs (10,5),(10,5),(11,5),(10,5) -> three writes with addresses 3210, 3211, 3210.
- **Backpressure and overflow:** ack held 0, 10 distinct valid pixels -> fifo_full_o=1 after the 8th push, overflow_o=1 latched, and after ack is released exactly the first 8 addresses are written in order.
- **Bounds:** (639,479) -> write to addr 307199. (640,0) and (0,480) -> no write.
- **Done:** 3 pixels then done_i, with ack delayed by 2 cycles per write -> done_o single pulse the cycle after the 3rd ack. A repeat of the last pixel after done_i is written again.
- **Reset mid-write:** rst asserted while mem_wr_o=1 with 4 entries queued -> next cycle all outputs at reset values; a subsequent ack produces no write and no done_o.

Source files
------------

// File: rtl/gpu_pixel_writer.sv
// gpu_pixel_writer
// Takes the rasterizer's per-cycle pixel stream and drops off-screen sentinels
// and back-to-back duplicates. Accepted pixels are turned into linear
// framebuffer addresses, paired with the current colour, and queued in a small
// FIFO. A request/acknowledge writer drains that FIFO into framebuffer memory.
// Ports:
//   clk, rst               rising-edge clock, synchronous active-high reset
//   X_i, Y_i               pixel coordinate (X=WIDTH / Y=HEIGHT is off-screen)
//   r_i, g_i, b_i          colour of the current primitive
//   done_i                 rasterizer end-of-primitive pulse
//   mem_wr_o/addr_o/data_o write request, held stable until mem_ack_i
//   mem_ack_i              memory accepted the current write
//   fifo_full_o            write buffer holds FIFO_DEPTH entries
//   overflow_o             sticky: a valid pixel was dropped on a full buffer
//   done_o                 one-cycle pulse once every primitive pixel is written
module gpu_pixel_writer #(
   parameter int WIDTH        = 640,
   parameter int HEIGHT       = 480,
   parameter int WIDTH_BITS   = 10,
   parameter int HEIGHT_BITS  = 9,
   parameter int CHANNEL_BITS = 8,
   parameter int ADDR_BITS    = 19,
   parameter int FIFO_DEPTH   = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [WIDTH_BITS-1:0]     X_i,
   input  logic [HEIGHT_BITS-1:0]    Y_i,
   input  logic [CHANNEL_BITS-1:0]   r_i,
   input  logic [CHANNEL_BITS-1:0]   g_i,
   input  logic [CHANNEL_BITS-1:0]   b_i,
   input  logic                      done_i,
   output logic                      mem_wr_o,
   output logic [ADDR_BITS-1:0]      mem_addr_o,
   output logic [3*CHANNEL_BITS-1:0] mem_data_o,
   input  logic                      mem_ack_i,
   output logic                      fifo_full_o,
   output logic                      overflow_o,
   output logic                      done_o
);

   localparam int DATA_BITS  = 3*CHANNEL_BITS;
   localparam int ENTRY_BITS = ADDR_BITS + DATA_BITS;
   localparam int PTR_BITS   = $clog2(FIFO_DEPTH);
   localparam logic [WIDTH_BITS-1:0]  X_LIM     = WIDTH_BITS'(WIDTH);
   localparam logic [HEIGHT_BITS-1:0] Y_LIM     = HEIGHT_BITS'(HEIGHT);
   localparam logic [PTR_BITS:0]      DEPTH_CNT = (PTR_BITS+1)'(FIFO_DEPTH);

   typedef enum logic {IDLE, REQ} state_t;

   state_t                  state;
   logic                    s1_valid;
   logic [WIDTH_BITS-1:0]   s1_x, last_x;
   logic [HEIGHT_BITS-1:0]  s1_y, last_y;
   logic [DATA_BITS-1:0]    s1_data;
   logic                    last_valid;
   logic                    done_pending;
   logic [ENTRY_BITS-1:0]   fifo_mem [FIFO_DEPTH];
   logic [PTR_BITS-1:0]     wr_ptr, rd_ptr, rd_ptr_inc;
   logic [PTR_BITS:0]       count, count_next;

   logic                    accept;
   logic [ADDR_BITS-1:0]    s1_addr;
   logic [ENTRY_BITS-1:0]   push_entry, head_next;
   logic                    full, pop, push_ok, done_fire;

   always_comb begin
      accept     = (X_i < X_LIM) && (Y_i < Y_LIM) &&
                   !(last_valid && X_i == last_x && Y_i == last_y);
      s1_addr    = ADDR_BITS'(s1_y) * ADDR_BITS'(WIDTH) + ADDR_BITS'(s1_x);
      push_entry = {s1_addr, s1_data};
      full       = (count == DEPTH_CNT);
      pop        = (state == REQ) && mem_ack_i;
      push_ok    = s1_valid && (!full || pop);
      count_next = count;
      if (push_ok && !pop)
         count_next = count + (PTR_BITS+1)'(1);
      else if (!push_ok && pop)
         count_next = count - (PTR_BITS+1)'(1);
      rd_ptr_inc = rd_ptr + PTR_BITS'(1);
      // After a pop the new head is either already stored or is the entry
      // being pushed on this very edge; bypass it so back-to-back writes need
      // no bubble.
      head_next  = (count > (PTR_BITS+1)'(1)) ? fifo_mem[rd_ptr_inc] : push_entry;
      done_fire  = done_pending && !s1_valid && (count == '0) && (state == IDLE);
   end

   assign fifo_full_o = full;
   assign done_o      = done_fire;

   // Qualify stage
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid   <= 1'b0;
         s1_x       <= '0;
         s1_y       <= '0;
         s1_data    <= '0;
         last_x     <= '0;
         last_y     <= '0;
         last_valid <= 1'b0;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_x    <= X_i;
            s1_y    <= Y_i;
            s1_data <= {r_i, g_i, b_i};
            last_x  <= X_i;
            last_y  <= Y_i;
         end
         // done_i wins so a pixel arriving with it cannot block a repeat
         // at the start of the next primitive.
         if (done_i)
            last_valid <= 1'b0;
         else if (accept)
            last_valid <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && push_ok)
         fifo_mem[wr_ptr] <= push_entry;
   end

   // FIFO pointers, overflow and done tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
         overflow_o   <= 1'b0;
         done_pending <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr <= wr_ptr + PTR_BITS'(1);
         if (pop)
            rd_ptr <= rd_ptr_inc;
         count <= count_next;
         if (s1_valid && full && !pop)
            overflow_o <= 1'b1;
         // A done_i coinciding with the pulse is merged into it.
         if (done_fire)
            done_pending <= 1'b0;
         else if (done_i)
            done_pending <= 1'b1;
      end
   end

   // Writer FSM
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         mem_wr_o   <= 1'b0;
         mem_addr_o <= '0;
         mem_data_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (count != '0) begin
                  state                    <= REQ;
                  mem_wr_o                 <= 1'b1;
                  {mem_addr_o, mem_data_o} <= fifo_mem[rd_ptr];
               end
            end
            REQ: begin
               if (mem_ack_i) begin
                  if (count_next != '0) begin
                     {mem_addr_o, mem_data_o} <= head_next;
                  end else begin
                     state    <= IDLE;
                     mem_wr_o <= 1'b0;
                  end
               end
            end
            default: begin
               state    <= IDLE;
               mem_wr_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gpu_pixel_writer.sv
module tb_gpu_pixel_writer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [9:0]  X_i = 10'd640;
   logic [8:0]  Y_i = 9'd480;
   logic [7:0]  r_i = '0, g_i = '0, b_i = '0;
   logic        done_i = 1'b0;
   logic        mem_wr_o;
   logic [18:0] mem_addr_o;
   logic [23:0] mem_data_o;
   logic        mem_ack_i = 1'b0;
   logic        fifo_full_o, overflow_o, done_o;

   gpu_pixel_writer #(.WIDTH(640), .HEIGHT(480), .WIDTH_BITS(10), .HEIGHT_BITS(9),
                      .CHANNEL_BITS(8), .ADDR_BITS(19), .FIFO_DEPTH(8)) dut (
      .clk(clk), .rst(rst), .X_i(X_i), .Y_i(Y_i), .r_i(r_i), .g_i(g_i), .b_i(b_i),
      .done_i(done_i), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
      .mem_data_o(mem_data_o), .mem_ack_i(mem_ack_i), .fifo_full_o(fifo_full_o),
      .overflow_o(overflow_o), .done_o(done_o));

   always #5 clk = ~clk;

   typedef struct { logic [18:0] a; logic [23:0] d; } wr_t;
   typedef struct { int x; int y; bit exp_wr; int exp_addr; } vec_t;

   int  errors = 0;
   int  checks = 0;
   wr_t wq[$];      // writes observed on the memory port
   wr_t exp_q[$];   // writes the model says must happen
   bit  rand_ack = 0;
   bit  mlast_v;
   int  mlast_x, mlast_y;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, got, got, exp, exp, $time);
      end
   endtask

   // Memory-side monitor: records completed handshakes and checks that a
   // stalled request holds its address and data.
   bit          prev_stall = 0;
   logic [18:0] prev_a;
   logic [23:0] prev_d;
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 0;
      end else begin
         if (prev_stall && mem_wr_o) begin
            check("hold_addr", 64'(mem_addr_o), 64'(prev_a));
            check("hold_data", 64'(mem_data_o), 64'(prev_d));
         end
         if (mem_wr_o && mem_ack_i) wq.push_back('{mem_addr_o, mem_data_o});
         prev_stall = mem_wr_o && !mem_ack_i;
         prev_a = mem_addr_o;
         prev_d = mem_data_o;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one coordinate with a fresh random colour and applies the
   // qualification rules to the model's expected-write list.
   task automatic pix(input int x, input int y);
      X_i = 10'(x); Y_i = 9'(y);
      r_i = 8'($urandom); g_i = 8'($urandom); b_i = 8'($urandom);
      if (x < 640 && y < 480 && !(mlast_v && x == mlast_x && y == mlast_y)) begin
         exp_q.push_back('{19'(y * 640 + x), {r_i, g_i, b_i}});
         mlast_x = x; mlast_y = y; mlast_v = 1;
      end
   endtask

   task automatic idle_in();
      X_i = 10'd640; Y_i = 9'd480;
   endtask

   task automatic pulse_done();
      done_i = 1'b1;
      mlast_v = 0;
      step();
      done_i = 1'b0;
   endtask

   task automatic wait_done(input string name);
      bit seen = done_o;
      for (int i = 0; i < 400 && !seen; i++) begin
         if (rand_ack) mem_ack_i = ($urandom % 4) != 0;
         step();
         if (done_o) seen = 1;
      end
      check(name, 64'(seen), 64'd1);
      step();
      check({name, "_single"}, 64'(done_o), 64'd0);
   endtask

   task automatic compare_writes(input string name);
      check({name, "_count"}, 64'(wq.size()), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < wq.size(); i++) begin
         check({name, "_addr"}, 64'(wq[i].a), 64'(exp_q[i].a));
         check({name, "_data"}, 64'(wq[i].d), 64'(exp_q[i].d));
      end
      wq.delete();
      exp_q.delete();
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_wr"},   64'(mem_wr_o),    64'd0);
      check({name, "_addr"}, 64'(mem_addr_o),  64'd0);
      check({name, "_data"}, 64'(mem_data_o),  64'd0);
      check({name, "_full"}, 64'(fifo_full_o), 64'd0);
      check({name, "_ovf"},  64'(overflow_o),  64'd0);
      check({name, "_done"}, 64'(done_o),      64'd0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      mlast_v = 0;
      wq.delete();
      exp_q.delete();
   endtask

   initial begin
      vec_t vecs[8];
      vecs[0] = '{3,    2,   1, 1283};
      vecs[1] = '{639,  479, 1, 307199};
      vecs[2] = '{640,  0,   0, 0};
      vecs[3] = '{0,    480, 0, 0};
      vecs[4] = '{0,    0,   1, 0};
      vecs[5] = '{1023, 511, 0, 0};
      vecs[6] = '{639,  0,   1, 639};
      vecs[7] = '{0,    479, 1, 306560};
      mlast_v = 0;

      // Reset state
      do_reset();
      check_reset_outputs("reset");

      // Single pixel: request rises two cycles after input, lasts one cycle
      mem_ack_i = 1'b1;
      pix(3, 2);
      step();
      idle_in();
      check("lat_e0_wr", 64'(mem_wr_o), 64'd0);
      step();
      check("lat_e1_wr", 64'(mem_wr_o), 64'd0);
      step();
      check("lat_e2_wr", 64'(mem_wr_o), 64'd1);
      check("lat_e2_addr", 64'(mem_addr_o), 64'd1283);
      check("lat_e2_data", 64'(mem_data_o), 64'(exp_q[0].d));
      step();
      check("lat_e3_wr", 64'(mem_wr_o), 64'd0);
      pulse_done();
      wait_done("single_done");
      compare_writes("single");

      // Table of bounds cases, each its own primitive
      for (int i = 0; i < 8; i++) begin
         int n = exp_q.size();
         pix(vecs[i].x, vecs[i].y);
         check("vec_model", 64'(exp_q.size() - n), 64'(vecs[i].exp_wr));
         if (vecs[i].exp_wr) check("vec_model_addr", 64'(exp_q[n].a), 64'(vecs[i].exp_addr));
         step();
         idle_in();
         pulse_done();
         wait_done("vec_done");
         compare_writes("vec");
      end

      // Duplicate filter
      pix(10, 5); step();
      pix(10, 5); step();
      pix(11, 5); step();
      pix(10, 5); step();
      idle_in();
      pulse_done();
      wait_done("dup_done");
      check("dup_model_n", 64'(exp_q.size()), 64'd3);
      check("dup_model_a", 64'(exp_q[2].a), 64'd3210);
      compare_writes("dup");

      // Backpressure and overflow
      mem_ack_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         pix(i, 7);
         step();
         if (i == 7) check("bp_full7", 64'(fifo_full_o), 64'd0);
         if (i == 8) begin
            check("bp_full8", 64'(fifo_full_o), 64'd1);
            check("bp_ovf8", 64'(overflow_o), 64'd0);
         end
         if (i == 9) check("bp_ovf9", 64'(overflow_o), 64'd1);
      end
      idle_in();
      step();
      step();
      check("bp_ovf", 64'(overflow_o), 64'd1);
      check("bp_full", 64'(fifo_full_o), 64'd1);
      check("bp_wr", 64'(mem_wr_o), 64'd1);
      check("bp_head", 64'(mem_addr_o), 64'd4480);
      exp_q = exp_q[0:7];
      mem_ack_i = 1'b1;
      pulse_done();
      wait_done("bp_done");
      check("bp_ovf_sticky", 64'(overflow_o), 64'd1);
      check("bp_full_after", 64'(fifo_full_o), 64'd0);
      compare_writes("bp");
      do_reset();
      check("bp_ovf_cleared", 64'(overflow_o), 64'd0);

      // Done timing with ack two cycles after each request
      mem_ack_i = 1'b0;
      pix(20, 1); step();
      pix(21, 1); step();
      pix(22, 1); step();
      idle_in();
      pulse_done();
      for (int w = 0; w < 3; w++) begin
         for (int i = 0; i < 20 && !mem_wr_o; i++) step();
         check("dn_req", 64'(mem_wr_o), 64'd1);
         check("dn_pre", 64'(done_o), 64'd0);
         step();
         step();
         check("dn_wait", 64'(done_o), 64'd0);
         mem_ack_i = 1'b1;
         step();
         mem_ack_i = 1'b0;
         check("dn_pulse", 64'(done_o), 64'(w == 2));
      end
      step();
      check("dn_single", 64'(done_o), 64'd0);
      compare_writes("dn");
      // Repeat of the final pixel after done_i is a new write
      mem_ack_i = 1'b1;
      pix(22, 1);
      check("rep_model", 64'(exp_q.size()), 64'd1);
      step();
      idle_in();
      pulse_done();
      wait_done("rep_done");
      compare_writes("rep");

      // Reset in the middle of a stalled write with 4 entries queued
      mem_ack_i = 1'b0;
      for (int i = 0; i < 4; i++) begin pix(30 + i, 2); step(); end
      idle_in();
      step();
      step();
      check("rst_mid_wr", 64'(mem_wr_o), 64'd1);
      rst = 1'b1;
      step();
      check_reset_outputs("rst_mid");
      rst = 1'b0;
      mlast_v = 0;
      exp_q.delete();
      mem_ack_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         check("rst_after_wr", 64'(mem_wr_o), 64'd0);
         check("rst_after_done", 64'(done_o), 64'd0);
      end
      check("rst_no_writes", 64'(wq.size()), 64'd0);
      wq.delete();

      // Randomized bursts (at most 7 cycles each, so no overflow) with random ack
      rand_ack = 1;
      for (int b = 0; b < 30; b++) begin
         int len = $urandom_range(7, 1);
         int px = 0, py = 0;
         for (int c = 0; c < len; c++) begin
            int k = $urandom % 4;
            if (k == 0) begin
               if ($urandom % 2) begin px = $urandom_range(1023, 640); py = $urandom % 480; end
               else begin px = $urandom % 640; py = $urandom_range(511, 480); end
            end else if (k == 1 && c > 0) begin
               // repeat the previous coordinate
            end else begin
               px = $urandom_range(639, 630);
               py = $urandom_range(479, 477);
            end
            pix(px, py);
            mem_ack_i = ($urandom % 4) != 0;
            step();
         end
         idle_in();
         pulse_done();
         wait_done("rnd_done");
         compare_writes("rnd");
      end
      check("rnd_no_ovf", 64'(overflow_o), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
